// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs buffered MDU results.
// MDU results drain into idle WB slots; prolonged denial raises stall_req.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_wb_en,
    input  logic [ADDR_W-1:0]           pipe_wb_addr,
    input  logic [DATA_W-1:0]           pipe_wb_data,
    input  logic                        mdu_valid,
    input  logic [ADDR_W-1:0]           mdu_addr,
    input  logic [DATA_W-1:0]           mdu_data,
    output logic                        mdu_ready,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic                        stall_req,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_nxt;
    logic              pipe_req;
    logic              head_valid;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign mdu_ready  = !rst && (fifo_count < CW'(FIFO_DEPTH));
    assign pipe_req   = pipe_wb_en && (pipe_wb_addr != '0);
    assign head_valid = (fifo_count != '0);
    assign push       = mdu_valid && mdu_ready;
    assign pop        = !pipe_req && head_valid;
    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    // Saturating count of cycles the queued head lost to the pipeline.
    always_comb begin
        starve_nxt = '0;
        if (head_valid && pipe_req) begin
            if (starve_cnt != SW'(STARVE_MAX))
                starve_nxt = starve_cnt + SW'(1);
            else
                starve_nxt = starve_cnt;
        end
    end

    // Result storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= mdu_addr;
            mem_data[wr_ptr] <= mdu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
        end
    end

    // Registered write port: pipeline first, then FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipe_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_wb_addr;
            rf_wdata <= pipe_wb_data;
        end else if (pop) begin
            rf_we    <= (head_addr != '0);
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Starvation tracking and pipeline freeze request.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            if (starve_nxt == SW'(STARVE_MAX))
                stall_req <= 1'b1;
            else if (pop)
                stall_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model.
// Directed scenarios first, then constrained-random traffic with rare resets.
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_wb_en;
    logic [AW-1:0] pipe_wb_addr;
    logic [DW-1:0] pipe_wb_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall_req;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_starve;
    logic          m_stall;

    wb_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW),
        .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_wb_en(pipe_wb_en),
        .pipe_wb_addr(pipe_wb_addr),
        .pipe_wb_data(pipe_wb_data),
        .mdu_valid(mdu_valid),
        .mdu_addr(mdu_addr),
        .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .stall_req(stall_req),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the reference model, from the rules of the block.
    task automatic model_step(input logic r);
        logic preq;
        logic hv;
        logic popped;
        logic rdy;
        ent_t e;
        if (r) begin
            q.delete();
            m_we     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_starve = 0;
            m_stall  = 1'b0;
            return;
        end
        rdy    = (q.size() < DEPTH);
        preq   = pipe_wb_en && (pipe_wb_addr != 0);
        hv     = (q.size() != 0);
        popped = 1'b0;
        if (preq) begin
            m_we   = 1'b1;
            m_addr = pipe_wb_addr;
            m_data = pipe_wb_data;
        end else if (hv) begin
            e      = q.pop_front();
            popped = 1'b1;
            m_we   = (e.a != 0);
            m_addr = e.a;
            m_data = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (popped || !hv)
            m_starve = 0;
        else if (m_starve < SMAX)
            m_starve = m_starve + 1;
        if (m_starve == SMAX)
            m_stall = 1'b1;
        else if (popped)
            m_stall = 1'b0;
        if (mdu_valid && rdy)
            q.push_back('{a: mdu_addr, d: mdu_data});
    endtask

    task automatic cycle(input logic en, input logic [AW-1:0] pa,
                         input logic [DW-1:0] pd, input logic mv,
                         input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input logic r);
        pipe_wb_en   = en;
        pipe_wb_addr = pa;
        pipe_wb_data = pd;
        mdu_valid    = mv;
        mdu_addr     = ma;
        mdu_data     = md;
        rst          = r;
        #1;
        chk("mdu_ready", 64'(mdu_ready),
            64'(!r && (q.size() < DEPTH)));
        model_step(r);
        @(posedge clk);
        #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
        chk("stall_req", 64'(stall_req), 64'(m_stall));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        m_we = 0; m_addr = 0; m_data = 0; m_starve = 0; m_stall = 0;
        pipe_wb_en = 0; pipe_wb_addr = 0; pipe_wb_data = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0; rst = 1;
        @(posedge clk);
        #1;

        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("reset_we", 64'(rf_we), 64'd0);
        chk("reset_cnt", 64'(fifo_count), 64'd0);
        chk("reset_ready", 64'(mdu_ready), 64'd1);

        cycle(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        chk("pipe_we", 64'(rf_we), 64'd1);
        chk("pipe_addr", 64'(rf_waddr), 64'd5);
        chk("pipe_data", 64'(rf_wdata), 64'h1234_5678);
        cycle(1, 0, 32'h1234_5678, 0, 0, 0, 0);
        chk("pipe_a0_we", 64'(rf_we), 64'd0);

        cycle(0, 0, 0, 1, 9, 32'hDEAD_BEEF, 0);
        chk("drain_cnt1", 64'(fifo_count), 64'd1);
        chk("drain_we0", 64'(rf_we), 64'd0);
        idle();
        chk("drain_we", 64'(rf_we), 64'd1);
        chk("drain_addr", 64'(rf_waddr), 64'd9);
        chk("drain_data", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("drain_cnt0", 64'(fifo_count), 64'd0);

        cycle(1, 3, 32'h11, 1, 10, 32'hA0, 0);
        cycle(1, 3, 32'h22, 1, 11, 32'hA1, 0);
        chk("full_cnt", 64'(fifo_count), 64'd2);
        cycle(1, 3, 32'h33, 1, 12, 32'hA2, 0);
        chk("full_cnt2", 64'(fifo_count), 64'd2);
        idle();
        chk("fifo_ord0", 64'(rf_waddr), 64'd10);
        idle();
        chk("fifo_ord1", 64'(rf_waddr), 64'd11);
        chk("fifo_empty", 64'(fifo_count), 64'd0);
        idle();

        cycle(1, 4, 32'h44, 1, 7, 32'h77, 0);
        for (int i = 0; i < SMAX; i++) begin
            chk("starve_lo", 64'(stall_req), 64'd0);
            cycle(1, 4, 32'h44, 0, 0, 0, 0);
        end
        chk("starve_hi", 64'(stall_req), 64'd1);
        idle();
        chk("starve_we", 64'(rf_waddr), 64'd7);
        chk("starve_clr", 64'(stall_req), 64'd0);

        cycle(1, 3, 32'h55, 1, 13, 32'hB0, 0);
        cycle(1, 3, 32'h66, 1, 14, 32'hB1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_cnt", 64'(fifo_count), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        repeat (3) begin
            idle();
            chk("rst_nowr", 64'(rf_we), 64'd0);
        end

        for (int i = 0; i < 4000; i++) begin
            logic en;
            en = ($urandom_range(0, 99) < 55);
            if (stall_req && $urandom_range(0, 9) != 0)
                en = 1'b0;
            cycle(en, AW'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 45),
                  AW'($urandom_range(0, 6)), $urandom(),
                  ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
